// File: rtl/core_id2ex_skid.sv
// core_id2ex_skid: registered ID->EX pipeline boundary with a two-entry skid
// buffer (main register + skid register). id_ready and ex_valid are both
// taken straight from flops, so nothing from ex_ready reaches id_ready in the
// same cycle.
//
// Optional feature: define CORE_ID2EX_BUBBLE_CLR_EN to clear the main payload
// to 0 whenever main goes invalid. In that mode the ALU sees ex_alu_inst = 0
// during bubbles. Without it, the main payload holds stale data while
// ex_valid = 0. The skid payload is never cleared outside reset.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. Valid never depends on ready. Once raised, valid and payload stay stable
// until the transfer. Ready may be high while valid is low; that cycle does
// nothing.

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ALU_INST_WIDTH
`define CORE_ALU_INST_WIDTH 12
`endif

module core_id2ex_skid #(
   parameter int XLEN  = `CORE_XLEN,
   parameter int ALU_W = `CORE_ALU_INST_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   // decode side
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [ALU_W-1:0] id_alu_inst,
   input  logic [XLEN-1:0]  id_rs1,
   input  logic [XLEN-1:0]  id_rs2,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rd,
   input  logic             id_rd_wen,
   // execute side
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [ALU_W-1:0] ex_alu_inst,
   output logic [XLEN-1:0]  ex_rs1,
   output logic [XLEN-1:0]  ex_rs2,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rd,
   output logic             ex_rd_wen,
   // debug view of the buffer state: 0 EMPTY, 1 FULL, 2 SKID
   output logic [1:0]       state_dbg
);

   localparam int PW = ALU_W + 4 * XLEN + 6;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,  // main invalid, skid invalid
      ST_FULL  = 2'd1,  // main valid,   skid invalid
      ST_SKID  = 2'd2   // main valid,   skid valid
   } state_t;

   state_t          state;
   logic [PW-1:0]   main_q;
   logic [PW-1:0]   skid_q;
   logic [PW-1:0]   id_payload;
   logic            up;
   logic            down;

   assign id_payload = {id_alu_inst, id_rs1, id_rs2, id_pc, id_imm, id_rd, id_rd_wen};
   assign {ex_alu_inst, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rd, ex_rd_wen} = main_q;

   assign up        = id_valid & id_ready;
   assign down      = ex_valid & ex_ready;
   assign state_dbg = state;

   // Buffer FSM with registered handshake outputs; flush overrides all traffic
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         ex_valid <= 1'b0;
         id_ready <= 1'b1;
         main_q   <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         // An up-transfer this cycle is dropped. A down-transfer is still
         // taken by EX, which squashes it itself.
         state    <= ST_EMPTY;
         ex_valid <= 1'b0;
         id_ready <= 1'b1;
`ifdef CORE_ID2EX_BUBBLE_CLR_EN
         main_q   <= '0;
`endif
      end else begin
         case (state)
            ST_EMPTY: begin
               if (up) begin
                  state    <= ST_FULL;
                  ex_valid <= 1'b1;
                  main_q   <= id_payload;
               end
            end
            ST_FULL: begin
               if (up && down) begin
                  main_q <= id_payload;
               end else if (down) begin
                  state    <= ST_EMPTY;
                  ex_valid <= 1'b0;
`ifdef CORE_ID2EX_BUBBLE_CLR_EN
                  main_q   <= '0;
`endif
               end else if (up) begin
                  // EX stalled while decode was still told ready: park it
                  state    <= ST_SKID;
                  id_ready <= 1'b0;
                  skid_q   <= id_payload;
               end
            end
            ST_SKID: begin
               // id_ready is 0 here, so only a down-transfer can happen
               if (down) begin
                  state    <= ST_FULL;
                  id_ready <= 1'b1;
                  main_q   <= skid_q;
               end
            end
            default: begin
               state    <= ST_EMPTY;
               ex_valid <= 1'b0;
               id_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_id2ex_skid.sv
// tb_core_id2ex_skid: scoreboard bench for core_id2ex_skid. The reference is
// a FIFO of at most two entries. EX sees the head entry, decode is ready while
// fewer than two entries are held, and flush or reset empties it.

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ALU_INST_WIDTH
`define CORE_ALU_INST_WIDTH 12
`endif

module tb_core_id2ex_skid;

   localparam int XLEN  = `CORE_XLEN;
   localparam int ALU_W = `CORE_ALU_INST_WIDTH;
   localparam int PW    = ALU_W + 4 * XLEN + 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             id_valid = 1'b0;
   logic             id_ready;
   logic [ALU_W-1:0] id_alu_inst = '0;
   logic [XLEN-1:0]  id_rs1 = '0, id_rs2 = '0, id_pc = '0, id_imm = '0;
   logic [4:0]       id_rd = '0;
   logic             id_rd_wen = 1'b0;
   logic             ex_valid;
   logic             ex_ready = 1'b0;
   logic [ALU_W-1:0] ex_alu_inst;
   logic [XLEN-1:0]  ex_rs1, ex_rs2, ex_pc, ex_imm;
   logic [4:0]       ex_rd;
   logic             ex_rd_wen;
   logic [1:0]       state_dbg;

   logic [PW-1:0]    exp_q[$];
   int               checks = 0;
   int               failures = 0;

   core_id2ex_skid #(.XLEN(XLEN), .ALU_W(ALU_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_alu_inst(id_alu_inst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_pc(id_pc), .id_imm(id_imm), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_inst(ex_alu_inst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Updated on every active edge from what the bench drove. A new entry is
   // pushed when decode offers and the model has room.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         automatic int  n    = exp_q.size();
         automatic bit  up   = id_valid && (n < 2);
         automatic bit  down = ex_ready && (n > 0);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (down) void'(exp_q.pop_front());
            if (up) exp_q.push_back({id_alu_inst, id_rs1, id_rs2, id_pc, id_imm, id_rd, id_rd_wen});
         end
      end
   end

   // ---------------- monitor ----------------
   // Away from the active edge: compare what the DUT presents with the model.
   always @(negedge clk) begin
      automatic int n = exp_q.size();
      check("ex_valid", 256'(ex_valid), 256'(n > 0));
      check("id_ready", 256'(id_ready), 256'(n < 2));
      check("state", 256'(state_dbg), 256'(n));
      if (ex_valid && n > 0)
         check("ex_payload",
               256'({ex_alu_inst, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rd, ex_rd_wen}),
               256'(exp_q[0]));
   end

   // ---------------- driver ----------------
   task automatic cycle(input logic v, input logic r, input logic f,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
      @(negedge clk);
      id_valid    = v;
      ex_ready    = r;
      flush       = f;
      id_pc       = pc;
      id_imm      = imm;
      id_alu_inst = ALU_W'($urandom);
      id_rs1      = XLEN'($urandom);
      id_rs2      = XLEN'($urandom);
      id_rd       = 5'($urandom);
      id_rd_wen   = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   initial begin
      // reset values
      #12;
      check("rst_ex_valid", 256'(ex_valid), 256'(0));
      check("rst_id_ready", 256'(id_ready), 256'(1));
      check("rst_payload",
            256'({ex_alu_inst, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rd, ex_rd_wen}), 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // streaming: pc 0x0..0x1C with ex_ready held high
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, XLEN'(i * 4), XLEN'($urandom));
      idle(3);

      // skid fill: FULL with 0x100, then accept 0x104 under backpressure
      cycle(1'b1, 1'b0, 1'b0, 32'h100, XLEN'($urandom));
      cycle(1'b1, 1'b0, 1'b0, 32'h104, XLEN'($urandom));
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      check("skid_state", 256'(state_dbg), 256'(2));
      check("skid_ex_pc", 256'(ex_pc), 256'(32'h100));
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      check("skid_drain_pc", 256'(ex_pc), 256'(32'h104));
      idle(2);

      // flush while in SKID with a simultaneous offer
      cycle(1'b1, 1'b0, 1'b0, 32'h300, '0);
      cycle(1'b1, 1'b0, 1'b0, 32'h304, '0);
      cycle(1'b1, 1'b0, 1'b1, 32'h308, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      check("flush_ex_valid", 256'(ex_valid), 256'(0));
      check("flush_id_ready", 256'(id_ready), 256'(1));
      cycle(1'b1, 1'b1, 1'b0, 32'h400, '0);
      idle(3);

      // async reset asserted mid-cycle while FULL
      cycle(1'b1, 1'b0, 1'b0, 32'h200, 32'h55);
      @(posedge clk);
      #2;
      id_valid = 1'b0;
      check("pre_rst_ex_valid", 256'(ex_valid), 256'(1));
      rst = 1'b1;
      #1;
      check("async_rst_ex_valid", 256'(ex_valid), 256'(0));
      check("async_rst_alu_inst", 256'(ex_alu_inst), 256'(0));
      check("async_rst_id_ready", 256'(id_ready), 256'(1));
      check("async_rst_imm", 256'(ex_imm), 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // bubble behaviour after draining a single instruction
      cycle(1'b1, 1'b1, 1'b0, 32'h500, 32'hDEADBEEF);
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      check("bubble_src_imm", 256'(ex_imm), 256'(32'hDEADBEEF));
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      check("bubble_ex_valid", 256'(ex_valid), 256'(0));
`ifdef CORE_ID2EX_BUBBLE_CLR_EN
      check("bubble_ex_imm", 256'(ex_imm), 256'(0));
`else
      check("bubble_ex_imm", 256'(ex_imm), 256'(32'hDEADBEEF));
`endif

      // random valid/ready/flush traffic
      for (int i = 0; i < 10000; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 63) == 0), XLEN'($urandom), XLEN'($urandom));
      idle(4);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_id2ex_skid.md
# core_id2ex_skid

Registered ID→EX pipeline boundary with a two-entry skid buffer. It sits directly upstream of the EX-stage ALU and presents the ALU with `alu_inst_bus`, `rs1`, `rs2`, `pc` and `imm`. It decouples decode from execute with a valid/ready handshake, sustains one instruction per cycle, and keeps `id_ready` fully registered so there is no combinational path from `ex_ready` to `id_ready`. It supports a synchronous flush for branch redirects.

## Interface
Parameters:
- `XLEN`, default `` `CORE_XLEN `` (32): datapath width.
- `ALU_W`, default `` `CORE_ALU_INST_WIDTH ``: width of the ALU one-hot instruction bus.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous pipeline kill; highest priority after reset.
- `id_valid` in 1: decode offers an instruction.
- `id_ready` out 1: buffer accepts an instruction; registered.
- `id_alu_inst` in ALU_W; `id_rs1`, `id_rs2`, `id_pc`, `id_imm` in XLEN each; `id_rd` in 5; `id_rd_wen` in 1: payload from decode.
- `ex_valid` out 1: an instruction is presented to EX.
- `ex_ready` in 1: EX consumes the presented instruction.
- `ex_alu_inst` out ALU_W; `ex_rs1`, `ex_rs2`, `ex_pc`, `ex_imm` out XLEN each; `ex_rd` out 5; `ex_rd_wen` out 1: payload to the ALU and writeback tag.

## Operation
- Storage: a main register, which drives the `ex_*` outputs, and a skid register of the same payload width.
- State machine:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- Handshakes:
  - An up-transfer occurs when `id_valid & id_ready`.
  - A down-transfer occurs when `ex_valid & ex_ready`.
- `id_ready = ~skid_valid`, taken from a flop. It is 1 in EMPTY and FULL and 0 in SKID.
- `ex_valid = main_valid`, taken from a flop.
- Transitions when there is no flush:
  - EMPTY + up → FULL; main ← id payload.
  - EMPTY + no up → EMPTY.
  - FULL + up + down → FULL; main ← id payload.
  - FULL + down only → EMPTY.
  - FULL + up only → SKID; skid ← id payload; main holds.
  - FULL + neither → FULL, hold.
  - SKID + down → FULL; main ← skid. No up is possible because `id_ready` = 0.
  - SKID + no down → SKID, hold.
- Ordering: strict FIFO. The skid entry is never overtaken.
- Flush:
  - Next state is EMPTY regardless of current state or handshakes.
  - Any up-transfer in the same cycle is discarded.
  - A down-transfer in the same cycle still counts as consumed by EX; EX is responsible for squashing it.
- `ex_valid` = 0 never asserts a request. `ex_ready` is allowed to be asserted while `ex_valid` = 0; that cycle has no effect.
- No width conversion: payload is passed bit-exact.

## Timing
- Reset values:
  - State EMPTY.
  - `ex_valid` = 0, `id_ready` = 1.
  - All `ex_*` payload outputs = 0, including `ex_alu_inst` = 0, which selects no ALU op.
- Latency: an up-transfer at edge N appears on `ex_*` with `ex_valid` = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 instruction per cycle whenever `ex_ready` is held at 1.
- Backpressure reaches decode one cycle late. The skid entry absorbs the single instruction accepted in that window.
- Reset mid-operation discards both entries immediately, asynchronously. The first accepted instruction after reset deasserts reaches EX 1 cycle after its handshake.
- Flush asserted in cycle N: `ex_valid` = 0 and `id_ready` = 1 after edge N.

## Configuration
- `CORE_ID2EX_BUBBLE_CLR_EN` defined:
  - Whenever main becomes invalid (drain, flush, reset), all main payload flops are cleared to 0.
  - The ALU therefore sees `ex_alu_inst` = 0 during bubbles, and its result is 0.
- Undefined:
  - Payload flops load only on accept and hold stale values while `ex_valid` = 0.
  - Consumers must qualify with `ex_valid`.
  - Skid payload is never cleared in either mode.

## Test plan
- Streaming: `ex_ready` = 1, `id_valid` = 1 for 8 cycles with `id_pc` = 0x0, 0x4, …, 0x1C → `ex_pc` follows 1 cycle later in order; `id_ready` stays 1; no bubbles.
- Skid fill:
  - Stimulus: FULL with `ex_pc` = 0x100; `ex_ready` = 0 while `id_pc` = 0x104 is accepted.
  - Response: state SKID, `id_ready` = 0 next cycle.
  - Then: `ex_ready` = 1 for 2 cycles → `ex_pc` = 0x100, then 0x104; `id_ready` returns to 1.
- Flush in SKID with a simultaneous `id_valid` → next cycle `ex_valid` = 0, `id_ready` = 1; nothing from before the flush ever appears on `ex_*`.
- Async reset asserted mid-cycle in FULL → `ex_valid` drops to 0 before the next edge; `ex_alu_inst` = 0, `id_ready` = 1.
- Bubble clear:
  - With `CORE_ID2EX_BUBBLE_CLR_EN` defined: drain a single instruction with `id_imm` = 0xDEADBEEF → `ex_imm` = 0 once `ex_valid` = 0.
  - Undefined: `ex_imm` holds 0xDEADBEEF.
- Random valid/ready toggling, 10k cycles, against a reference FIFO model → no loss, no duplication, order preserved, `id_ready` equals the registered value of `~skid_valid` every cycle.
